// File: rtl/warp_scheduler.sv
// Warp table with round-robin issue: holds {pc, mask} and an IDLE/READY/WAIT state per warp.
// Latency: spawn or update in cycle N makes the warp READY at N+1; issue_valid rises at N+2.
// Backpressure: issue_ready low freezes the issue register; spawn_ready low while the target warp is busy.
module warp_scheduler #(
    parameter int MACHINE_WIDTH        = 64,
    parameter int NUM_WARPS            = 8,
    parameter int LOG2_NUM_WARPS       = 3,
    parameter int NUM_THREADS_PER_WARP = 8,
    parameter int PC_INC               = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            spawn_valid,
    input  logic [LOG2_NUM_WARPS-1:0]       spawn_warp_id,
    input  logic [MACHINE_WIDTH-1:0]        spawn_pc,
    input  logic [NUM_THREADS_PER_WARP-1:0] spawn_mask,
    output logic                            spawn_ready,
    output logic                            issue_valid,
    input  logic                            issue_ready,
    output logic [LOG2_NUM_WARPS-1:0]       issue_warp_id,
    output logic [MACHINE_WIDTH-1:0]        issue_pc,
    output logic [NUM_THREADS_PER_WARP-1:0] issue_mask,
    input  logic                            upd_valid,
    input  logic [LOG2_NUM_WARPS-1:0]       upd_warp_id,
    input  logic                            upd_jump,
    input  logic [MACHINE_WIDTH-1:0]        upd_target,
    input  logic [NUM_THREADS_PER_WARP-1:0] upd_mask,
    input  logic                            upd_halt,
    output logic [NUM_WARPS-1:0]            active_warps
);

    typedef enum logic [1:0] {W_IDLE, W_READY, W_WAIT} wstate_t;

    typedef struct packed {
        logic [MACHINE_WIDTH-1:0]        pc;
        logic [NUM_THREADS_PER_WARP-1:0] mask;
    } entry_t;

    wstate_t                   state_q [NUM_WARPS];
    wstate_t                   state_d [NUM_WARPS];
    entry_t                    ent_q   [NUM_WARPS];
    entry_t                    ent_d   [NUM_WARPS];
    logic [LOG2_NUM_WARPS-1:0] ptr_q;
    logic [LOG2_NUM_WARPS-1:0] sel_id;
    logic [LOG2_NUM_WARPS-1:0] cand;
    logic                      sel_found;
    logic                      issue_load;
    logic [NUM_WARPS-1:0]      active_d;

    assign spawn_ready = (state_q[spawn_warp_id] == W_IDLE);
    assign issue_load  = !issue_valid || issue_ready;

    // Round-robin scan starting just after the last selected warp; works for non power-of-two counts.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_WARPS; k++) begin
            cand = LOG2_NUM_WARPS'((int'(ptr_q) + k) % NUM_WARPS);
            if (!sel_found && state_q[cand] == W_READY) begin
                sel_found = 1'b1;
                sel_id    = cand;
            end
        end
    end

    // Spawn hits only IDLE, update only WAIT, selection only READY, so the three never collide.
    always_comb begin
        state_d = state_q;
        ent_d   = ent_q;
        if (spawn_valid && spawn_ready) begin
            ent_d[spawn_warp_id].pc   = spawn_pc;
            ent_d[spawn_warp_id].mask = spawn_mask;
            state_d[spawn_warp_id]    = (spawn_mask == '0) ? W_IDLE : W_READY;
        end
        if (upd_valid && state_q[upd_warp_id] == W_WAIT) begin
            if (upd_halt || upd_mask == '0) begin
                state_d[upd_warp_id] = W_IDLE;
            end else begin
                state_d[upd_warp_id]    = W_READY;
                ent_d[upd_warp_id].pc   = upd_jump ? upd_target
                                        : ent_q[upd_warp_id].pc + MACHINE_WIDTH'(PC_INC);
                ent_d[upd_warp_id].mask = upd_mask;
            end
        end
        if (issue_load && sel_found) begin
            state_d[sel_id] = W_WAIT;
        end
    end

    always_comb begin
        active_d = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            active_d[w] = (state_d[w] != W_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                state_q[w] <= W_IDLE;
                ent_q[w]   <= '0;
            end
            ptr_q         <= LOG2_NUM_WARPS'(NUM_WARPS - 1);
            issue_valid   <= 1'b0;
            issue_warp_id <= '0;
            issue_pc      <= '0;
            issue_mask    <= '0;
            active_warps  <= '0;
        end else begin
            state_q      <= state_d;
            ent_q        <= ent_d;
            active_warps <= active_d;
            if (issue_load) begin
                issue_valid <= sel_found;
                if (sel_found) begin
                    issue_warp_id <= sel_id;
                    issue_pc      <= ent_q[sel_id].pc;
                    issue_mask    <= ent_q[sel_id].mask;
                    ptr_q         <= sel_id;
                end
            end
        end
    end

endmodule

// File: doc/warp_scheduler.md
Name: warp_scheduler

Overview:
- Parametrised warp table plus round-robin issue scheduler for the SIMD front end.
- Holds one {warpID, pc, mask} entry and a state per warp.
- Accepts warp spawns, issues one ready warp per cycle to fetch through a registered valid/ready port, and retires or redirects warps from branch-resolution updates.
- Generalises the fixed warp-record layout to arbitrary warp count, thread count, machine width and PC increment.

Parameters:
MACHINE_WIDTH, 64, width of pc/target fields
NUM_WARPS, 8, number of warp table entries (>=2)
LOG2_NUM_WARPS, 3, clog2(NUM_WARPS)
NUM_THREADS_PER_WARP, 8, thread mask width
PC_INC, 1, sequential pc step (1 for word addressing, 4 for byte addressing)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
spawn_valid  in  1  spawn request
spawn_warp_id  in  LOG2_NUM_WARPS  warp to start
spawn_pc  in  MACHINE_WIDTH  start pc
spawn_mask  in  NUM_THREADS_PER_WARP  initial thread mask
spawn_ready  out  1  target warp is IDLE (combinational from spawn_warp_id)
issue_valid  out  1  issue register holds a warp
issue_ready  in  1  fetch accepts the issue
issue_warp_id  out  LOG2_NUM_WARPS  issued warp id
issue_pc  out  MACHINE_WIDTH  issued pc
issue_mask  out  NUM_THREADS_PER_WARP  issued mask
upd_valid  in  1  resolution update for a waiting warp
upd_warp_id  in  LOG2_NUM_WARPS  updated warp
upd_jump  in  1  1 = pc <- upd_target, 0 = pc <- pc+PC_INC
upd_target  in  MACHINE_WIDTH  jump target
upd_mask  in  NUM_THREADS_PER_WARP  new thread mask
upd_halt  in  1  retire warp
active_warps  out  NUM_WARPS  bit w = warp w not IDLE (registered)

Behaviour:
- Per-warp state: IDLE, READY, WAIT.
- Reset: all warps IDLE; pc and mask 0; issue_valid 0; issue_* 0; active_warps 0; RR pointer = NUM_WARPS-1, so the search starts at warp 0.
- Reset is honoured mid-operation and overrides all inputs in that cycle.
- Spawn:
  - Accepted when spawn_valid & spawn_ready.
  - The entry loads pc/mask. Next state is READY, or IDLE if spawn_mask == 0.
  - spawn_valid with a non-IDLE target is ignored; the entry is unchanged.
- Issue register (valid/ready):
  - Loads when it is empty or draining (!issue_valid | issue_ready).
  - Selection: the first READY warp scanning from (ptr+1) mod NUM_WARPS upward, with wrap-around.
  - On load: outputs take the selected entry, issue_valid=1, the warp goes READY->WAIT, and ptr takes the selected id.
  - If no warp is READY at load time: issue_valid=0.
  - While issue_valid & !issue_ready, all issue_* outputs hold stable and no selection occurs.
- Latency: spawn at cycle N gives READY at N+1. It is selected at N+1 if the register is free, so issue_valid=1 from N+2.
- Update:
  - Applies only when upd_valid and the target warp is WAIT; otherwise it is ignored.
  - upd_halt=1 or upd_mask==0: warp goes to IDLE.
  - Otherwise the warp goes to READY, with pc <- upd_jump ? upd_target : pc+PC_INC and mask <- upd_mask.
  - pc addition is modulo 2^MACHINE_WIDTH (wraps).
- Simultaneous events:
  - Spawn, update and selection may all occur in one cycle.
  - A warp updated in cycle N is READY at N+1 and is first selectable at N+1 (not N).
  - Spawn and update cannot hit the same warp, because IDLE and WAIT are exclusive.
- Each warp has at most one instruction outstanding (in the issue register or downstream).
- active_warps reflects state after the clock edge (registered, 1-cycle after spawn/halt).

Test Plan:
1. Reset, then idle inputs -> issue_valid=0, active_warps=0x00, spawn_ready=1 for every id; reasserting rst mid-run with a warp in WAIT -> all state cleared the next cycle.
2. Spawn warp 2, pc=0x100, mask=0xFF at cycle N, issue_ready=1 -> issue_valid=1 at N+2 with id 2, pc 0x100, mask 0xFF; active_warps=0x04 at N+1; a second spawn to warp 2 -> spawn_ready=0 and the spawn is ignored.
3. Warps 1, 3 and 5 spawned, each updated (upd_jump=0) one cycle after its issue -> issue order 1,3,5,1,3,5; pcs increment by PC_INC each round.
4. issue_ready held low 5 cycles with warp 4 in the register -> issue_* stable all 5 cycles; warp 4 issued exactly once on release.
5. Update warp 1 with jump=1, target=0x40, mask=0x0F -> next issue of warp 1 is pc=0x40, mask=0x0F. Update with halt=1 -> warp 1 IDLE, active bit cleared, never issued again. Update with mask=0 -> same result as halt.
6. Warp 0 spawned at pc=all-ones, updated with jump=0 -> next issue pc=0x0. Update to a READY or IDLE warp -> ignored, no state change.
